// File: rtl/fme_candidate_search_if.sv
// Bus bundle for fme_candidate_search: start/row handshake, pixel rows, costs and result.
// diff_out/diff_valid exist only when FME_SEARCH_DIFF_OUT_EN is defined.

interface fme_candidate_search_if #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 8,
    parameter int CANDS     = 8,
    parameter int SAD_W     = DATAWIDTH + 9
);
    logic                                 enable;
    logic                                 valid_in;
    logic [LANES*DATAWIDTH-1:0]           original;
    logic [CANDS*LANES*DATAWIDTH-1:0]     candidate;
    logic [CANDS*(DATAWIDTH+8)-1:0]       lambda_r_sad;
    logic [SAD_W-1:0]                     best_sad_ime;
    logic                                 busy;
    logic                                 done;
    logic [$clog2(CANDS+1)-1:0]           address_best_sad;
    logic [SAD_W-1:0]                     best_sad;
`ifdef FME_SEARCH_DIFF_OUT_EN
    logic [LANES*(DATAWIDTH+1)-1:0]       diff_out;
    logic                                 diff_valid;
`endif

    modport master (
        output enable, valid_in, original, candidate, lambda_r_sad, best_sad_ime,
`ifdef FME_SEARCH_DIFF_OUT_EN
        input  diff_out, diff_valid,
`endif
        input  busy, done, address_best_sad, best_sad
    );

    modport slave (
        input  enable, valid_in, original, candidate, lambda_r_sad, best_sad_ime,
`ifdef FME_SEARCH_DIFF_OUT_EN
        output diff_out, diff_valid,
`endif
        output busy, done, address_best_sad, best_sad
    );
endinterface

// File: rtl/fme_candidate_search.sv
// FME candidate search: per-candidate saturating SAD over ROWS rows, add lambda*R, argmin vs IME cost.
// Optional macro FME_SEARCH_DIFF_OUT_EN adds registered original-minus-candidate-0 difference outputs.

module fme_candidate_search #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 8,
    parameter int CANDS     = 8,
    parameter int ROWS      = 8,
    parameter int SAD_W     = DATAWIDTH + 9
) (
    input logic                    i_clock,
    input logic                    i_reset,
    fme_candidate_search_if.slave  bus
);
    localparam int LAM_W = DATAWIDTH + 8;
    localparam int ROW_W = DATAWIDTH + $clog2(LANES) + 1;
    localparam int AW    = $clog2(CANDS + 1);
    localparam int IW    = (CANDS > 1) ? $clog2(CANDS) : 1;
    localparam int RW    = $clog2(ROWS + 1);
    localparam int MAX1  = (SAD_W > ROW_W) ? SAD_W : ROW_W;
    localparam int MAX2  = (MAX1 > LAM_W) ? MAX1 : LAM_W;
    localparam int SUM_W = MAX2 + 1;
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-SAD_W){1'b0}}, {SAD_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COST, S_FIND} state_t;

    state_t             r_state;
    logic [SAD_W-1:0]   r_acc [CANDS];
    logic [RW-1:0]      r_row;
    logic [IW-1:0]      r_idx;
    logic [SAD_W-1:0]   r_min;
    logic [AW-1:0]      r_min_idx;
    logic               r_busy;
    logic               r_done;
    logic [AW-1:0]      r_addr;
    logic [SAD_W-1:0]   r_best;

    logic [ROW_W-1:0]   w_row_sad [CANDS];
    logic [SAD_W-1:0]   w_cur;
    logic               w_take;

    function automatic logic [DATAWIDTH-1:0] f_absdiff(input logic [DATAWIDTH-1:0] a,
                                                      input logic [DATAWIDTH-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [SAD_W-1:0] f_sat(input logic [SUM_W-1:0] s);
        return (s > SAT_MAX) ? {SAD_W{1'b1}} : s[SAD_W-1:0];
    endfunction

    // Per-candidate row SAD; sized so a full row can never overflow before the saturating add.
    always_comb begin
        for (int unsigned k = 0; k < CANDS; k++) begin
            w_row_sad[k] = '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                w_row_sad[k] = w_row_sad[k] + ROW_W'(f_absdiff(
                    bus.original[l*DATAWIDTH +: DATAWIDTH],
                    bus.candidate[(k*LANES+l)*DATAWIDTH +: DATAWIDTH]));
            end
        end
    end

    // Strict less-than keeps the earlier holder on ties, so the IME incumbent wins all ties.
    assign w_cur  = r_acc[r_idx];
    assign w_take = (w_cur < r_min);

`ifdef FME_SEARCH_DIFF_OUT_EN
    logic [LANES*(DATAWIDTH+1)-1:0] r_diff_out;
    logic                           r_diff_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_diff_out   <= '0;
            r_diff_valid <= 1'b0;
        end else begin
            r_diff_valid <= 1'b0;
            if (r_state == S_ACCUM && bus.valid_in) begin
                r_diff_valid <= 1'b1;
                for (int unsigned l = 0; l < LANES; l++) begin
                    r_diff_out[l*(DATAWIDTH+1) +: (DATAWIDTH+1)] <=
                        {1'b0, bus.original[l*DATAWIDTH +: DATAWIDTH]} -
                        {1'b0, bus.candidate[l*DATAWIDTH +: DATAWIDTH]};
                end
            end
        end
    end

    assign bus.diff_out   = r_diff_out;
    assign bus.diff_valid = r_diff_valid;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_idx     <= '0;
            r_min     <= '0;
            r_min_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_best    <= '0;
            for (int unsigned k = 0; k < CANDS; k++) r_acc[k] <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        for (int unsigned k = 0; k < CANDS; k++) r_acc[k] <= '0;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (bus.valid_in) begin
                        for (int unsigned k = 0; k < CANDS; k++)
                            r_acc[k] <= f_sat(SUM_W'(r_acc[k]) + SUM_W'(w_row_sad[k]));
                        r_row <= r_row + 1'b1;
                        if (r_row == RW'(ROWS - 1)) r_state <= S_COST;
                    end
                end
                S_COST: begin
                    for (int unsigned k = 0; k < CANDS; k++)
                        r_acc[k] <= f_sat(SUM_W'(r_acc[k]) +
                                          SUM_W'(bus.lambda_r_sad[k*LAM_W +: LAM_W]));
                    r_min     <= bus.best_sad_ime;
                    r_min_idx <= AW'(CANDS);
                    r_idx     <= '0;
                    r_state   <= S_FIND;
                end
                S_FIND: begin
                    if (w_take) begin
                        r_min     <= w_cur;
                        r_min_idx <= AW'(r_idx);
                    end
                    r_idx <= r_idx + 1'b1;
                    // Last compare folds straight into the result registers.
                    if (r_idx == IW'(CANDS - 1)) begin
                        r_best  <= w_take ? w_cur : r_min;
                        r_addr  <= w_take ? AW'(r_idx) : r_min_idx;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.address_best_sad = r_addr;
    assign bus.best_sad         = r_best;

endmodule

// File: tb/tb_fme_candidate_search.sv
// Directed self-checking bench for fme_candidate_search (default build and SAD_W=16 instance).
// Also exercises diff_out/diff_valid when FME_SEARCH_DIFF_OUT_EN is defined.

module tb_fme_candidate_search;
    localparam int DW = 8;
    localparam int L  = 8;
    localparam int C  = 8;
    localparam int R  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fme_candidate_search_if #(.DATAWIDTH(DW), .LANES(L), .CANDS(C)) bus ();
    fme_candidate_search_if #(.DATAWIDTH(DW), .LANES(L), .CANDS(C), .SAD_W(16)) bus16 ();

    fme_candidate_search #(.DATAWIDTH(DW), .LANES(L), .CANDS(C), .ROWS(R)) u_dut (
        .i_clock(clk), .i_reset(rst), .bus(bus)
    );

    fme_candidate_search #(.DATAWIDTH(DW), .LANES(L), .CANDS(C), .ROWS(R), .SAD_W(16)) u_dut16 (
        .i_clock(clk), .i_reset(rst), .bus(bus16)
    );

    task automatic set_orig(input int v);
        for (int l = 0; l < L; l++) bus.original[l*DW +: DW] = DW'(v);
    endtask

    task automatic set_cand(input int k, input int v);
        for (int l = 0; l < L; l++) bus.candidate[(k*L+l)*DW +: DW] = DW'(v);
    endtask

    task automatic set_lambda(input int v);
        for (int k = 0; k < C; k++) bus.lambda_r_sad[k*16 +: 16] = 16'(v);
    endtask

    task automatic start();
        bus.enable = 1'b1;  bus16.enable = 1'b1;
        bus.valid_in = 1'b1; bus16.valid_in = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;  bus16.enable = 1'b0;
        bus.valid_in = 1'b0; bus16.valid_in = 1'b0;
    endtask

    task automatic feed(input int gaps, input bit pulse);
        logic [L*DW-1:0] saved;
        for (int r = 0; r < R; r++) begin
            bus.valid_in = 1'b1; bus16.valid_in = 1'b1;
            @(negedge clk);
            bus.valid_in = 1'b0; bus16.valid_in = 1'b0;
            if (gaps > 0 && r < R - 1) begin
                saved = bus.original;
                bus.original = ~saved;
                bus.enable = pulse; bus16.enable = pulse;
                repeat (gaps) @(negedge clk);
                bus.enable = 1'b0; bus16.enable = 1'b0;
                bus.original = saved;
            end
        end
    endtask

    // Returns number of edges after the last-row edge until done is observed; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.address_best_sad !== 4'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus.address_best_sad); end
        total++; if (bus.best_sad !== 17'd0) begin bad++; $display("FAIL reset_best: got %0d want 0", bus.best_sad); end
        total++; if (bus16.best_sad !== 16'd0) begin bad++; $display("FAIL reset_best16: got %0d want 0", bus16.best_sad); end
`ifdef FME_SEARCH_DIFF_OUT_EN
        total++; if (bus.diff_valid !== 1'b0 || bus.diff_out !== '0) begin
            bad++; $display("FAIL reset_diff: got valid=%b out=%h want 0", bus.diff_valid, bus.diff_out); end
`endif
    endtask

    // Candidate k differs by k in every pixel: SAD_k = 64*k, candidate 0 cost 0.
    task automatic test_basic();
        int lat;
        set_orig(10);
        for (int k = 0; k < C; k++) set_cand(k, 10 + k);
        set_lambda(0);
        bus.best_sad_ime = 17'd100;
        start();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise: got %b want 1", bus.busy); end
        feed(0, 1'b0);
        wait_done(lat);
        total++; if (lat != 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", bus.busy); end
        total++; if (bus.address_best_sad !== 4'd0) begin bad++; $display("FAIL basic_addr: got %0d want 0", bus.address_best_sad); end
        total++; if (bus.best_sad !== 17'd0) begin bad++; $display("FAIL basic_best: got %0d want 0", bus.best_sad); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    endtask

    // Candidate 3 exact, others SAD 64, lambda 5: costs 5 vs 69.
    task automatic test_ime_compare();
        int lat;
        set_orig(10);
        for (int k = 0; k < C; k++) set_cand(k, 11);
        set_cand(3, 10);
        set_lambda(5);
        bus.best_sad_ime = 17'd4;
        start(); feed(0, 1'b0); wait_done(lat);
        total++; if (lat != 9 || bus.address_best_sad !== 4'd8 || bus.best_sad !== 17'd4) begin
            bad++; $display("FAIL ime_wins: got lat=%0d addr=%0d best=%0d want lat=9 addr=8 best=4",
                            lat, bus.address_best_sad, bus.best_sad); end
        bus.best_sad_ime = 17'd6;
        start(); feed(0, 1'b0); wait_done(lat);
        total++; if (lat != 9 || bus.address_best_sad !== 4'd3 || bus.best_sad !== 17'd5) begin
            bad++; $display("FAIL cand3_wins: got lat=%0d addr=%0d best=%0d want lat=9 addr=3 best=5",
                            lat, bus.address_best_sad, bus.best_sad); end
    endtask

    // Candidates 2 and 5 cost 20 (SAD 0 + lambda 20), others 84.
    task automatic test_tie();
        int lat;
        set_orig(10);
        for (int k = 0; k < C; k++) set_cand(k, 11);
        set_cand(2, 10);
        set_cand(5, 10);
        set_lambda(20);
        bus.best_sad_ime = 17'd30;
        start(); feed(0, 1'b0); wait_done(lat);
        total++; if (bus.address_best_sad !== 4'd2 || bus.best_sad !== 17'd20) begin
            bad++; $display("FAIL tie_earlier: got addr=%0d best=%0d want addr=2 best=20",
                            bus.address_best_sad, bus.best_sad); end
        bus.best_sad_ime = 17'd20;
        start(); feed(0, 1'b0); wait_done(lat);
        total++; if (bus.address_best_sad !== 4'd8 || bus.best_sad !== 17'd20) begin
            bad++; $display("FAIL tie_ime: got addr=%0d best=%0d want addr=8 best=20",
                            bus.address_best_sad, bus.best_sad); end
    endtask

    // SAD = 64*255 = 16320 per candidate; +65535 saturates at 16 bits but not at 17 bits.
    task automatic test_saturation();
        int lat;
        for (int l = 0; l < L; l++) bus16.original[l*DW +: DW] = 8'd255;
        bus16.candidate = '0;
        for (int k = 0; k < C; k++) bus16.lambda_r_sad[k*16 +: 16] = 16'hFFFF;
        bus16.best_sad_ime = 16'hFFFF;
        set_orig(255);
        for (int k = 0; k < C; k++) set_cand(k, 0);
        set_lambda(16'hFFFF);
        bus.best_sad_ime = 17'd100000;
        start(); feed(0, 1'b0); wait_done(lat);
        total++; if (bus16.done !== 1'b1) begin bad++; $display("FAIL sat_done16: got %b want 1", bus16.done); end
        total++; if (bus16.best_sad !== 16'd65535 || bus16.address_best_sad !== 4'd8) begin
            bad++; $display("FAIL sat16: got addr=%0d best=%0d want addr=8 best=65535",
                            bus16.address_best_sad, bus16.best_sad); end
        total++; if (bus.best_sad !== 17'd81855 || bus.address_best_sad !== 4'd0) begin
            bad++; $display("FAIL nosat17: got addr=%0d best=%0d want addr=0 best=81855",
                            bus.address_best_sad, bus.best_sad); end
    endtask

    task automatic test_gaps_enable();
        int lat;
        int dones;
        set_orig(10);
        for (int k = 0; k < C; k++) set_cand(k, 11);
        set_cand(3, 10);
        set_lambda(5);
        bus.best_sad_ime = 17'd6;
        start(); feed(2, 1'b1); wait_done(lat);
        total++; if (lat != 9 || bus.address_best_sad !== 4'd3 || bus.best_sad !== 17'd5) begin
            bad++; $display("FAIL gaps_result: got lat=%0d addr=%0d best=%0d want lat=9 addr=3 best=5",
                            lat, bus.address_best_sad, bus.best_sad); end
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL gaps_single_done: got %0d extra dones want 0", dones); end
    endtask

    task automatic test_reset_mid_find();
        int lat;
        int dones;
        set_orig(10);
        for (int k = 0; k < C; k++) set_cand(k, 11);
        set_cand(3, 10);
        set_lambda(5);
        bus.best_sad_ime = 17'd6;
        start(); feed(0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.address_best_sad !== 4'd0 || bus.best_sad !== 17'd0) begin
            bad++; $display("FAIL midreset_outputs: got busy=%b addr=%0d best=%0d want 0 0 0",
                            bus.busy, bus.address_best_sad, bus.best_sad); end
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", dones); end
        start(); feed(0, 1'b0); wait_done(lat);
        total++; if (lat != 9 || bus.address_best_sad !== 4'd3 || bus.best_sad !== 17'd5) begin
            bad++; $display("FAIL midreset_rerun: got lat=%0d addr=%0d best=%0d want lat=9 addr=3 best=5",
                            lat, bus.address_best_sad, bus.best_sad); end
    endtask

    // Enable raised in the done cycle must start the next search.
    task automatic test_back_to_back();
        int lat;
        set_orig(10);
        for (int k = 0; k < C; k++) set_cand(k, 11);
        set_cand(3, 10);
        set_lambda(5);
        bus.best_sad_ime = 17'd6;
        start(); feed(0, 1'b0); wait_done(lat);
        bus.best_sad_ime = 17'd4;
        start();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", bus.busy); end
        feed(0, 1'b0); wait_done(lat);
        total++; if (lat != 9 || bus.address_best_sad !== 4'd8 || bus.best_sad !== 17'd4) begin
            bad++; $display("FAIL b2b_result: got lat=%0d addr=%0d best=%0d want lat=9 addr=8 best=4",
                            lat, bus.address_best_sad, bus.best_sad); end
    endtask

`ifdef FME_SEARCH_DIFF_OUT_EN
    task automatic test_diff_out();
        int lat;
        int highs;
        logic [L*(DW+1)-1:0] exp_diff;
        exp_diff = {L{9'h138}};
        set_orig(0);
        for (int k = 0; k < C; k++) set_cand(k, 0);
        set_cand(0, 200);
        set_lambda(0);
        bus.best_sad_ime = 17'd100;
        start();
        highs = 0;
        for (int r = 0; r < R; r++) begin
            bus.valid_in = 1'b1; bus16.valid_in = 1'b1;
            @(negedge clk);
            if (bus.diff_valid === 1'b1) highs++;
            total++; if (bus.diff_out !== exp_diff) begin
                bad++; $display("FAIL diff_value: got %h want %h", bus.diff_out, exp_diff); end
        end
        bus.valid_in = 1'b0; bus16.valid_in = 1'b0;
        total++; if (highs != 8) begin bad++; $display("FAIL diff_valid_count: got %0d want 8", highs); end
        @(negedge clk);
        total++; if (bus.diff_valid !== 1'b0) begin bad++; $display("FAIL diff_valid_drop: got %b want 0", bus.diff_valid); end
        for (int c = 2; c <= 9; c++) @(negedge clk);
        total++; if (bus.done !== 1'b1 || bus.address_best_sad !== 4'd1 || bus.best_sad !== 17'd0) begin
            bad++; $display("FAIL diff_search: got done=%b addr=%0d best=%0d want 1 1 0",
                            bus.done, bus.address_best_sad, bus.best_sad); end
        wait_done(lat);
    endtask
`endif

    initial begin
        bus.enable = 1'b0;  bus.valid_in = 1'b0;
        bus.original = '0;  bus.candidate = '0;
        bus.lambda_r_sad = '0; bus.best_sad_ime = '0;
        bus16.enable = 1'b0; bus16.valid_in = 1'b0;
        bus16.original = '0; bus16.candidate = '0;
        bus16.lambda_r_sad = '0; bus16.best_sad_ime = '0;

        test_reset();
        test_basic();
        test_ime_compare();
        test_tie();
        test_saturation();
        test_gaps_enable();
        test_reset_mid_find();
        test_back_to_back();
`ifdef FME_SEARCH_DIFF_OUT_EN
        test_diff_out();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
